sgf_seq_multiplier: RTL and testbench

Sequential radix-2 shift-add multiplier for unsigned floating-point significands (hidden bit included). It sits directly upstream of the product register in the multiplication datapath. The block accepts two SW-bit operands with a start pulse and iterates one partial product per cycle. It then presents the 2·SW-bit product together with a one-cycle `ready_o` strobe, which drives the product register's load input.

---
 rtl/sgf_seq_multiplier.sv | 79 +++++++
 tb/tb_sgf_seq_multiplier.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sgf_seq_multiplier.sv
// rtl/sgf_seq_multiplier.sv - radix-2 shift-add multiplier for unsigned significands
// One partial product per cycle; ready_o strobes the product register load.
module sgf_seq_multiplier #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [SW-1:0]   Data_A_i,
    input  logic [SW-1:0]   Data_B_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [2*SW-1:0] sgf_result_o
);

    localparam int CW = $clog2(SW + 1);
    localparam logic [CW-1:0] LAST = CW'(SW - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [SW-1:0]     mcand, mcand_nx;
    logic [2*SW:0]     p, p_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [2*SW-1:0]   result_nx;
    logic [SW:0]       psum;

    // Upper half holds partial sum plus carry; lower half the unconsumed multiplier bits.
    assign psum = p[2*SW:SW] + (p[0] ? {1'b0, mcand} : '0);

    always_comb begin
        state_nx  = state;
        mcand_nx  = mcand;
        p_nx      = p;
        cnt_nx    = cnt;
        result_nx = sgf_result_o;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    mcand_nx = Data_A_i;
                    p_nx     = {{(SW + 1){1'b0}}, Data_B_i};
                    cnt_nx   = '0;
                    state_nx = CALC;
                end else if (state == DONE) begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                p_nx   = {1'b0, psum, p[SW-1:1]};
                cnt_nx = cnt + CW'(1);
                if (cnt == LAST) begin
                    result_nx = p_nx[2*SW-1:0];
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mcand        <= '0;
            p            <= '0;
            cnt          <= '0;
            sgf_result_o <= '0;
        end else begin
            state        <= state_nx;
            mcand        <= mcand_nx;
            p            <= p_nx;
            cnt          <= cnt_nx;
            sgf_result_o <= result_nx;
        end
    end

    assign busy_o  = (state == CALC);
    assign ready_o = (state == DONE);

endmodule

// File: tb/tb_sgf_seq_multiplier.sv
// tb/tb_sgf_seq_multiplier.sv - directed scoreboard bench for sgf_seq_multiplier
module tb_sgf_seq_multiplier;

    localparam int SW = 24;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [SW-1:0]   Data_A_i;
    logic [SW-1:0]   Data_B_i;
    logic            busy_o;
    logic            ready_o;
    logic [2*SW-1:0] sgf_result_o;

    logic [2*SW-1:0] sb[$];
    int total = 0;
    int bad   = 0;

    sgf_seq_multiplier #(.SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .Data_A_i     (Data_A_i),
        .Data_B_i     (Data_B_i),
        .busy_o       (busy_o),
        .ready_o      (ready_o),
        .sgf_result_o (sgf_result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*SW-1:0] model(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [2*SW-1:0] e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check(tag, 64'(sgf_result_o), 64'(e));
        end
    endtask

    // Drive one start pulse, then wait for the strobe; latency counted in negedges after the start edge.
    task automatic run_op(input string tag, input logic [SW-1:0] a, input logic [SW-1:0] b);
        int lat;
        int busy_cnt;
        lat = -1;
        busy_cnt = 0;
        @(negedge clk);
        Data_A_i = a;
        Data_B_i = b;
        start_i  = 1'b1;
        sb.push_back(model(a, b));
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 0) begin
                start_i  = 1'b0;
                Data_A_i = $urandom;
                Data_B_i = $urandom;
            end
            if (ready_o) begin
                lat = i;
                break;
            end
            if (busy_o) busy_cnt++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(SW));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(SW));
        if (lat >= 0) pop_check({tag, "_result"});
        else if (sb.size() != 0) void'(sb.pop_front());
    endtask

    initial begin
        int n1;
        int n2;
        int ready_seen;
        logic [2*SW-1:0] first_res;

        rst      = 1'b0;
        start_i  = 1'b0;
        Data_A_i = '0;
        Data_B_i = '0;
        #1;
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", 64'(sgf_result_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_op("one_x_one", 24'h800000, 24'h800000);
        check("one_x_one_const", 64'(sgf_result_o), 64'h400000000000);
        run_op("onehalf_sq", 24'hC00000, 24'hC00000);
        check("onehalf_sq_const", 64'(sgf_result_o), 64'h900000000000);
        run_op("zero_a", 24'h000000, 24'hABCDEF);
        check("zero_a_const", 64'(sgf_result_o), 64'd0);

        // Ignored start during CALC, then start held through DONE for a back-to-back op.
        @(negedge clk);
        Data_A_i = 24'h123456;
        Data_B_i = 24'h654321;
        start_i  = 1'b1;
        sb.push_back(model(24'h123456, 24'h654321));
        first_res = model(24'h123456, 24'h654321);
        n1 = -1;
        for (int i = 0; i < 60 && n1 < 0; i++) begin
            @(negedge clk);
            if (i == 0) start_i = 1'b0;
            if (i == 5) begin
                Data_A_i = 24'h000001;
                Data_B_i = 24'h000001;
                start_i  = 1'b1;
            end
            if (i == 6) start_i = 1'b0;
            if (i == 20) begin
                Data_A_i = 24'd3;
                Data_B_i = 24'd5;
                start_i  = 1'b1;
            end
            if (ready_o) n1 = i;
        end
        check("b2b_first_latency", 64'(n1), 64'(SW));
        if (n1 >= 0) pop_check("b2b_first_result");
        else if (sb.size() != 0) void'(sb.pop_front());
        sb.push_back(model(24'd3, 24'd5));
        n2 = -1;
        for (int i = 1; i < 60 && n2 < 0; i++) begin
            @(negedge clk);
            if (i == 1) start_i = 1'b0;
            if (ready_o) n2 = i;
            else check("b2b_first_stable", 64'(sgf_result_o), 64'(first_res));
        end
        check("b2b_second_gap", 64'(n2), 64'(SW + 1));
        if (n2 >= 0) pop_check("b2b_second_result");
        else if (sb.size() != 0) void'(sb.pop_front());
        check("b2b_second_const", 64'(sgf_result_o), 64'h00000000000F);

        run_op("max_sq", 24'hFFFFFF, 24'hFFFFFF);
        check("max_sq_const", 64'(sgf_result_o), 64'hFFFFFE000001);

        // Asynchronous reset in the middle of a run aborts it without a strobe.
        @(negedge clk);
        Data_A_i = 24'hFFFFFF;
        Data_B_i = 24'h000002;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_abort_busy", 64'(busy_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy_o), 64'd0);
        check("abort_ready", 64'(ready_o), 64'd0);
        check("abort_result", 64'(sgf_result_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o) ready_seen++;
        end
        check("abort_no_ready", 64'(ready_seen), 64'd0);

        run_op("post_reset", 24'h800001, 24'h7FFFFF);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
